// File: rtl/fixed_multiplier.sv
// Iterative shift-add multiply-accumulate: Product = inQuotient * inDivisor + inRemainder, one multiplier bit per clock.
// Define FIXED_MULT_OVF_CHECK_EN to register Overflow at completion; otherwise Overflow is tied low.
module fixed_multiplier #(
  parameter int QW = 32,
  parameter int DW = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [QW-1:0]      inQuotient,
  input  logic [DW-1:0]      inDivisor,
  input  logic [DW-1:0]      inRemainder,
  output logic               busy,
  output logic               done,
  output logic [QW+DW-1:0]   Product,
  output logic               Overflow
);

  localparam int PW = QW + DW;
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [PW-1:0]   r_mcand;
  logic [PW-1:0]   r_acc;
  logic [PW-1:0]   r_product;
  logic [DW-1:0]   r_mplier;
  logic [CW-1:0]   r_count;

  logic            w_accept;
  logic            w_last;
  logic [PW-1:0]   w_acc_nxt;

  // A start in RUN is dropped, not queued.
  assign w_accept  = start && (r_state != S_RUN);
  assign w_last    = (r_state == S_RUN) && (r_count == CW'(DW - 1));
  assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (start)  w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mcand   <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_mplier  <= '0;
      r_count   <= '0;
    end else if (w_accept) begin
      r_mcand   <= PW'(inQuotient);
      r_mplier  <= inDivisor;
      r_acc     <= PW'(inRemainder);
      r_count   <= '0;
    end else if (r_state == S_RUN) begin
      r_acc     <= w_acc_nxt;
      r_mcand   <= r_mcand << 1;
      r_mplier  <= r_mplier >> 1;
      r_count   <= r_count + CW'(1);
      // Product only moves at completion so it holds the previous result while iterating.
      if (w_last) begin
        r_product <= w_acc_nxt;
      end
    end
  end

  assign busy    = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);
  assign Product = r_product;

`ifdef FIXED_MULT_OVF_CHECK_EN
  logic r_ovf;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= |w_acc_nxt[PW-1:QW];
    end
  end

  assign Overflow = r_ovf;
`else
  assign Overflow = 1'b0;
`endif

endmodule

// File: tb/tb_fixed_multiplier.sv
// Bench for fixed_multiplier: transaction-level model checked every cycle plus directed literal vectors.
module tb_fixed_multiplier;

  localparam int QW = 32;
  localparam int DW = 16;
  localparam int PW = QW + DW;

`ifdef FIXED_MULT_OVF_CHECK_EN
  localparam logic EXP_OVF_MAX = 1'b1;
`else
  localparam logic EXP_OVF_MAX = 1'b0;
`endif

  logic          clock       = 1'b0;
  logic          reset_n     = 1'b1;
  logic          start       = 1'b0;
  logic [QW-1:0] inQuotient  = '0;
  logic [DW-1:0] inDivisor   = '0;
  logic [DW-1:0] inRemainder = '0;
  logic          busy;
  logic          done;
  logic [PW-1:0] Product;
  logic          Overflow;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  fixed_multiplier #(.QW(QW), .DW(DW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .inQuotient  (inQuotient),
    .inDivisor   (inDivisor),
    .inRemainder (inRemainder),
    .busy        (busy),
    .done        (done),
    .Product     (Product),
    .Overflow    (Overflow)
  );

  // Reference: one pending job with a countdown; the result is plain arithmetic taken at acceptance.
  logic          m_busy = 1'b0;
  logic          m_done = 1'b0;
  logic          m_ovf  = 1'b0;
  logic [PW-1:0] m_prod = '0;
  logic [PW-1:0] m_res  = '0;
  int            m_rem  = 0;

  function automatic logic ovf_of(input logic [PW-1:0] p);
`ifdef FIXED_MULT_OVF_CHECK_EN
    return (p >> QW) != '0;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_prod <= '0;
      m_ovf  <= 1'b0;
      m_rem  <= 0;
    end else if (m_busy) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_prod <= m_res;
        m_ovf  <= ovf_of(m_res);
      end
    end else if (start) begin
      m_res  <= PW'(64'(inQuotient) * 64'(inDivisor) + 64'(inRemainder));
      m_rem  <= DW;
      m_busy <= 1'b1;
      m_done <= 1'b0;
      m_ovf  <= 1'b0;
    end
  end

  always @(negedge clock) begin
    checks++;
    if ({busy, done, Overflow, Product} !== {m_busy, m_done, m_ovf, m_prod}) begin
      failures++;
      $display("FAIL model_cycle t=%0t busy=%b/%b done=%b/%b ovf=%b/%b prod=%h/%h (actual/required)",
               $time, busy, m_busy, done, m_done, Overflow, m_ovf, Product, m_prod);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge. lat counts edges from the accepting edge to the first done sample.
  task automatic run_op(input logic [QW-1:0] q, input logic [DW-1:0] d, input logic [DW-1:0] r,
                        output int lat, output int bcnt);
    inQuotient  = q;
    inDivisor   = d;
    inRemainder = r;
    start       = 1'b1;
    @(posedge clock);
    #1;
    start       = 1'b0;
    inQuotient  = $urandom;
    inDivisor   = 16'($urandom);
    inRemainder = 16'($urandom);
    lat  = 0;
    bcnt = busy ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      lat++;
      if (done) break;
      if (busy) bcnt++;
    end
  endtask

  initial begin
    int lat;
    int bcnt;
    int cyc;
    int last;
    int ndone;
    logic [31:0] dividend;
    logic [15:0] divisor;

    #1 reset_n = 1'b0;
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_prod", 64'(Product), 64'd0);
    chk("reset_ovf", 64'(Overflow), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;

    run_op(32'd100, 16'd7, 16'd3, lat, bcnt);
    chk("basic_latency", 64'(lat), 64'd16);
    chk("basic_busy_cycles", 64'(bcnt), 64'd16);
    chk("basic_prod", 64'(Product), 64'd703);
    chk("basic_ovf", 64'(Overflow), 64'd0);
    chk("model_basic_prod", 64'(m_prod), 64'd703);

    run_op(32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF, lat, bcnt);
    chk("max_latency", 64'(lat), 64'd16);
    chk("max_prod", 64'(Product), 64'hFFFF_0000_0000);
    chk("max_ovf", 64'(Overflow), 64'(EXP_OVF_MAX));
    chk("model_max_prod", 64'(m_prod), 64'hFFFF_0000_0000);

    run_op(32'd5, 16'd0, 16'd9, lat, bcnt);
    chk("zero_latency", 64'(lat), 64'd16);
    chk("zero_prod", 64'(Product), 64'd9);

    // A start pulse at T0+5 must be ignored.
    inQuotient = 32'd100; inDivisor = 16'd7; inRemainder = 16'd3; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    inQuotient = 32'd2; inDivisor = 16'd2; inRemainder = 16'd0; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    lat = 5;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      lat++;
      if (done) break;
    end
    chk("ignore_latency", 64'(lat), 64'd16);
    chk("ignore_prod", 64'(Product), 64'd703);
    repeat (3) @(posedge clock);
    #1;
    chk("ignore_no_second_busy", 64'(busy), 64'd0);
    chk("ignore_done_held", 64'(done), 64'd1);
    chk("ignore_prod_held", 64'(Product), 64'd703);

    // Asynchronous reset in the middle of an operation.
    inQuotient = 32'd1234; inDivisor = 16'd56; inRemainder = 16'd7; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (8) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_done", 64'(done), 64'd0);
    chk("midreset_prod", 64'(Product), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;
    run_op(32'd1234, 16'd56, 16'd7, lat, bcnt);
    chk("after_reset_latency", 64'(lat), 64'd16);
    chk("after_reset_prod", 64'(Product), 64'd69111);

    // start held high: a completion every DW+1 cycles, operands churning every cycle.
    start = 1'b1;
    cyc   = 0;
    last  = -1;
    ndone = 0;
    for (int i = 0; i < 150 && ndone < 6; i++) begin
      inQuotient  = $urandom;
      inDivisor   = 16'($urandom);
      inRemainder = 16'($urandom);
      @(posedge clock);
      #1;
      cyc++;
      if (done) begin
        if (last >= 0) chk("b2b_interval", 64'(cyc - last), 64'd17);
        last = cyc;
        ndone++;
      end
    end
    start = 1'b0;
    chk("b2b_completions", 64'(ndone), 64'd6);
    @(posedge clock);
    #1;

    // Divide in the bench, re-multiply in the DUT, expect the original dividend back.
    for (int k = 0; k < 8; k++) begin
      dividend = $urandom;
      divisor  = 16'($urandom_range(1, 65535));
      run_op(dividend / 32'(divisor), divisor, 16'(dividend % 32'(divisor)), lat, bcnt);
      chk("roundtrip_prod", 64'(Product), 64'(dividend));
      chk("roundtrip_ovf", 64'(Overflow), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fixed_multiplier.md
Name: fixed_multiplier

Overview:
- Sequential shift-add multiply-accumulate unit: Product = inQuotient * inDivisor + inRemainder.
- Inverse partner of the team's fixed restoring divider. It reconstructs a dividend from a quotient/divisor/remainder triple.
- Serves as the datapath's multiply engine and as a self-check path for the divider (divide, then re-multiply, then compare).
- Iterative: one multiplier bit per clock, start/busy/done handshake.

Parameters:
- QW, 32, width of inQuotient (multiplicand).
- DW, 16, width of inDivisor (multiplier) and inRemainder; also the iteration count.

Ports:
- clock  input  1  rising-edge clock (the single clock).
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on rising clock edge.
- inQuotient  input  QW  multiplicand.
- inDivisor  input  DW  multiplier.
- inRemainder  input  DW  addend.
- busy  output  1  high while iterating.
- done  output  1  high when Product is valid; held until next accepted start.
- Product  output  QW+DW  result.
- Overflow  output  1  high when result exceeds QW bits (see Optional Feature).

Behaviour:
- Reset (async, reset_n=0):
  - State is IDLE.
  - busy=0, done=0, Product=0, Overflow=0, count=0.
  - Internal accumulator and operand registers are cleared.
  - Takes effect immediately, including mid-operation. The in-flight operation is discarded with no partial result exposed.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 at edge T0:
  - Latch inQuotient into multiplicand register M (zero-extended to QW+DW).
  - Latch inDivisor into multiplier shift register B.
  - Load accumulator A = {QW zeros, inRemainder}.
  - Set count=0, busy=1, done=0, and go to RUN.
- RUN, each edge:
  - If B[0]=1, A = A + M (QW+DW-bit add). The sum never exceeds QW+DW bits by construction.
  - Then M = M << 1, B = B >> 1, count = count + 1.
- Exit from RUN: on the edge where count reaches DW (the DW-th RUN edge, T0+DW):
  - Product = final A.
  - busy=0, done=1, go to DONE.
- Latency: done rises exactly DW edges after the accepting edge (16 cycles at default).
- Operand inputs are don't-care after T0; later changes do not affect the result.
- start while in RUN is ignored. No queuing and no restart.
- Product and done hold in DONE until the next accepted start. On that edge done drops and Product keeps its old value until the new completion.
- start held high continuously gives back-to-back operations: DONE lasts one cycle, then RUN restarts.
- inDivisor=0: Product=inRemainder after the full DW cycles. There is no early exit, so latency is fixed.
- Arithmetic is unsigned throughout. inRemainder is not checked against inDivisor; any DW-bit value is added.

Optional Feature:
- Macro: FIXED_MULT_OVF_CHECK_EN.
- Defined:
  - Overflow is registered at completion as OR of Product[QW+DW-1:QW]. This means the result does not fit a QW-bit dividend.
  - Overflow is valid with done and held in DONE.
  - It clears on reset and on accepted start.
- Not defined: the Overflow port remains but is tied to constant 0. No extra logic.

Test Plan:
- Basic: reset_n pulse, then start with inQuotient=100, inDivisor=7, inRemainder=3. Required: busy=1 for 16 cycles, done at T0+16, Product=703, Overflow=0.
- Max operands: inQuotient=0xFFFFFFFF, inDivisor=0xFFFF, inRemainder=0xFFFF. Required: Product=0xFFFF_0000_0000. Overflow=1 with FIXED_MULT_OVF_CHECK_EN, else 0.
- Zero multiplier: inQuotient=5, inDivisor=0, inRemainder=9. Required: done at T0+16 (not earlier), Product=9.
- Busy-ignore: start 100*7+3, then pulse start with 2*2+0 at T0+5. Required: completion stays at T0+16 with Product=703, and no second operation begins.
- Reset mid-op: start 1234*56+7, drop reset_n at T0+8. Required: immediately busy=0, done=0, Product=0. After release, start 1234*56+7. Required: Product=69111 at the new T0+16.
- Back-to-back/round-trip: hold start high with random operands and compare each Product against a reference model. Required: a new done every 17 cycles. Also feed divider outputs back in and check Product equals the original 32-bit dividend, with Overflow=0.
